// File: rtl/pair_pkg.sv
// Shared definitions for the pair-coded bit line: FSM states, two-bit symbol
// constants and the data-bit encoder used by the transmitter and receivers.
package pair_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_STOP = 2'd3
    } state_e;

    // Symbols are sent MSB first: bit [1] is the first line bit, bit [0] the second.
    localparam logic [1:0] SYM_PRE  = 2'b01;
    localparam logic [1:0] SYM_ONE  = 2'b11;
    localparam logic [1:0] SYM_ZERO = 2'b10;
    localparam logic [1:0] SYM_STOP = 2'b00;

    function automatic logic [1:0] encode(input logic b);
        return b ? SYM_ONE : SYM_ZERO;
    endfunction

endpackage

// File: rtl/pair_tx.sv
// Pair-code serial transmitter: accepts one word per frame and sends
// preamble, LSB-first data and a stop symbol, one line bit per cycle.
module pair_tx
    import pair_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PRE_PAIRS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              outp,
    output logic              busy,
    output logic              done
);

    localparam int MAXC = (DATA_W > PRE_PAIRS) ? DATA_W : PRE_PAIRS;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_PAIRS - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);

    // state_q/half_q/cnt_q describe the line bit currently on outp_q.
    state_e              state_q, state_d;
    logic                half_q, half_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   sr_q, sr_d;
    logic                outp_q, outp_d;

    logic [DATA_W-1:0]   sr_shift;
    logic [1:0]          cur_sym, nxt_sym;

    assign sr_shift = sr_q >> 1;
    assign cur_sym  = encode(sr_q[0]);
    assign nxt_sym  = encode(sr_shift[0]);

    always_comb begin
        state_d = state_q;
        half_d  = ~half_q;
        cnt_d   = half_q ? cnt_q + CW'(1) : cnt_q;
        sr_d    = sr_q;
        outp_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                half_d = 1'b0;
                cnt_d  = '0;
                if (valid_in) begin
                    sr_d    = data_in;
                    state_d = ST_PRE;
                    outp_d  = SYM_PRE[1];
                end
            end
            ST_PRE: begin
                if (!half_q) begin
                    outp_d = SYM_PRE[0];
                end else if (cnt_q == PRE_LAST) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    outp_d  = cur_sym[1];
                end else begin
                    outp_d = SYM_PRE[1];
                end
            end
            ST_DATA: begin
                if (!half_q) begin
                    outp_d = cur_sym[0];
                end else begin
                    // Symbol complete: next symbol comes from the shifted word.
                    sr_d = sr_shift;
                    if (cnt_q == DATA_LAST) begin
                        state_d = ST_STOP;
                        cnt_d   = '0;
                        outp_d  = SYM_STOP[1];
                    end else begin
                        outp_d = nxt_sym[1];
                    end
                end
            end
            ST_STOP: begin
                if (!half_q) begin
                    outp_d = SYM_STOP[0];
                end else begin
                    state_d = ST_IDLE;
                    half_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                half_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            half_q  <= 1'b0;
            cnt_q   <= '0;
            sr_q    <= '0;
            outp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            outp_q  <= outp_d;
        end
    end

    assign outp      = outp_q;
    assign ready_out = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_STOP) && half_q;

endmodule

// File: tb/tb_pair_tx.sv
// Scoreboard bench for pair_tx: stimulus pushes hand-written line-bit streams,
// per-instance monitors pop and compare every busy cycle.
module tb_pair_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data;
    logic       valid;
    logic       ready, outp, busy, done;
    logic [3:0] data2;
    logic       valid2;
    logic       ready2, outp2, busy2, done2;
    bit         mon_en = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic o;
        logic d;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    pair_tx #(.DATA_W(8), .PRE_PAIRS(2)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data), .valid_in(valid),
        .ready_out(ready), .outp(outp), .busy(busy), .done(done)
    );

    pair_tx #(.DATA_W(4), .PRE_PAIRS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .data_in(data2), .valid_in(valid2),
        .ready_out(ready2), .outp(outp2), .busy(busy2), .done(done2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Push n line bits, first bit is v[n-1]; done is expected on the last one.
    task automatic push_bits(input logic [63:0] v, input int n, input bit to2);
        exp_t e;
        for (int i = n - 1; i >= 0; i--) begin
            e.o = v[i];
            e.d = (i == 0);
            if (to2) q2.push_back(e);
            else     q1.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (busy) begin
                if (q1.size() == 0) begin
                    chk("m1_unexpected_busy", 1, 0);
                end else begin
                    e = q1.pop_front();
                    chk("m1_outp", outp, e.o);
                    chk("m1_done", done, e.d);
                end
            end else begin
                chk("m1_idle_outp", outp, 0);
                chk("m1_idle_done", done, 0);
            end
            chk("m1_ready", ready, !busy);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (busy2) begin
                if (q2.size() == 0) begin
                    chk("m2_unexpected_busy", 1, 0);
                end else begin
                    e = q2.pop_front();
                    chk("m2_outp", outp2, e.o);
                    chk("m2_done", done2, e.d);
                end
            end else begin
                chk("m2_idle_outp", outp2, 0);
                chk("m2_idle_done", done2, 0);
            end
            chk("m2_ready", ready2, !busy2);
        end
    end

    task automatic send(input logic [7:0] d);
        int t = 0;
        while (!ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("send_ready_wait", ready, 1);
        @(negedge clk);
        #2;
        valid = 1'b1;
        data  = d;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        @(negedge clk);
        while (busy && t < 60) begin
            @(negedge clk);
            t++;
        end
        #1;
        chk({name, "_ends"}, busy, 0);
        chk({name, "_ready"}, ready, 1);
        chk({name, "_drained"}, q1.size(), 0);
    endtask

    initial begin
        int t;
        rst_n  = 1'b1;
        valid  = 1'b0;
        data   = '0;
        valid2 = 1'b0;
        data2  = '0;

        // Asynchronous reset asserted mid-cycle.
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_outp", outp, 0);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst2_busy", busy2, 0);
        repeat (2) @(negedge clk);
        #2;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single frame 8'hA5.
        push_bits(22'b01_01_11_10_11_10_10_11_10_11_00, 22, 1'b0);
        send(8'hA5);
        wait_idle("a5");

        // Back-to-back FF then 00 with valid held high.
        @(negedge clk);
        #2;
        push_bits(22'b01_01_11_11_11_11_11_11_11_11_00, 22, 1'b0);
        push_bits(22'b01_01_10_10_10_10_10_10_10_10_00, 22, 1'b0);
        valid = 1'b1;
        data  = 8'hFF;
        @(posedge clk);
        #1;
        data = 8'h00;
        t = 0;
        while (!done && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("b2b_first_done", done, 1);
        @(negedge clk);
        chk("b2b_gap_ready", ready, 1);
        chk("b2b_gap_busy", busy, 0);
        chk("b2b_gap_outp", outp, 0);
        @(negedge clk);
        chk("b2b_second_start", busy, 1);
        #2;
        valid = 1'b0;
        wait_idle("b2b");

        // Valid pulse with 8'h3C during an 8'h01 frame must be ignored.
        push_bits(22'b01_01_11_10_10_10_10_10_10_10_00, 22, 1'b0);
        send(8'h01);
        repeat (5) @(negedge clk);
        #2;
        chk("ign_ready_low", ready, 0);
        valid = 1'b1;
        data  = 8'h3C;
        @(posedge clk);
        #1;
        valid = 1'b0;
        wait_idle("ign");
        repeat (5) @(negedge clk);
        #1;
        chk("ign_no_second_frame", busy, 0);

        // Reset at cycle 10 of an 8'hC3 frame, then 8'h5A accepted on the first edge after release.
        push_bits(22'b01_01_11_11_10_10_10_10_11_11_00, 22, 1'b0);
        send(8'hC3);
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_outp", outp, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ready", ready, 1);
        q1.delete();
        valid = 1'b1;
        data  = 8'h5A;
        push_bits(22'b01_01_10_11_10_11_11_10_11_10_00, 22, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        chk("rel_accept_busy", busy, 1);
        wait_idle("5a");

        // Narrow instance: DATA_W=4, PRE_PAIRS=1, data 4'b0110.
        push_bits(12'b01_10_11_11_10_00, 12, 1'b1);
        @(negedge clk);
        #2;
        valid2 = 1'b1;
        data2  = 4'b0110;
        @(posedge clk);
        #1;
        valid2 = 1'b0;
        t = 0;
        @(negedge clk);
        while (busy2 && t < 40) begin
            @(negedge clk);
            t++;
        end
        #1;
        chk("p4_ends", busy2, 0);
        chk("p4_ready", ready2, 1);
        chk("p4_drained", q2.size(), 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pair_tx.md
# pair_tx

Serial line-code transmitter and the send end of the pair-coded bit line: the pair detector is the receive end. Accepts one parallel word through a valid/ready handshake and drives it onto a one-bit line as a framed sequence of two-bit symbols. The frame is a preamble, then the data LSB-first, then a stop symbol. It sits between a parallel producer and the serial line, and drives test sequences into the pair detector.

## Interface
- `DATA_W`, default 8: data bits per frame, ≥1.
- `PRE_PAIRS`, default 2: number of preamble symbols, ≥1.
- `clk` input, 1 bit: the only clock; all state changes on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `data_in` input, `DATA_W` bits: word to send; sampled only at accept.
- `valid_in` input, 1 bit: producer has a word.
- `ready_out` output, 1 bit: block can accept; high only in IDLE.
- `outp` output, 1 bit: serial line bit, registered.
- `busy` output, 1 bit: a frame is in progress (state ≠ IDLE).
- `done` output, 1 bit: one-cycle pulse while the last line bit of a frame is on `outp`.

## Operation
- **Line code:** one symbol is two consecutive line bits (first, second).
  - PRE = 01.
  - data 1 = 11.
  - data 0 = 10.
  - STOP = 00.
  - Idle line = 0.
- **States:** IDLE, PRE, DATA, STOP.
- **Internal registers:**
  - `half` (0 = first bit of the symbol, 1 = second bit).
  - Symbol counter, width clog2(max(`DATA_W`, `PRE_PAIRS`)) + 1.
  - `DATA_W`-bit shift register.
- **IDLE:**
  - `outp` = 0, `ready_out` = 1.
  - On `valid_in` && `ready_out`: load the shift register with `data_in`, clear the counter, set `half` = 0, go to PRE.
  - `outp` takes the first PRE bit (0) on this same edge.
- **PRE:** emit PRE `PRE_PAIRS` times, then go to DATA.
- **DATA:**
  - Emit the symbol for shift register bit 0.
  - When a symbol completes, shift right by 1.
  - After `DATA_W` symbols, go to STOP.
- **STOP:** emit 00, then go to IDLE. `outp` = 0 on that edge.
- Every state advances one line bit per cycle. `half` toggles each cycle. The counter increments when `half` = 1.
- `valid_in` while not in IDLE: ignored; no data is lost from the shift register.
- `data_in` changes after accept: no effect on the current frame.

## Timing
- **Reset values (while `rst_n` = 0, asynchronously):**
  - State = IDLE.
  - `outp` = 0, `ready_out` = 1, `busy` = 0, `done` = 0.
  - Counters, `half` and shift register = 0.
- **Frame length:** L = 2·(`PRE_PAIRS` + `DATA_W` + 1) cycles of `busy` = 1. L = 22 at the defaults.
- **Latency:**
  - First line bit appears on `outp` in the cycle right after the accept edge.
  - `done` is high during cycle L after accept; STOP's second bit is on `outp` in that cycle.
- **End of frame and back-to-back:**
  - `ready_out` returns to 1 in the cycle after `done`.
  - Back-to-back frames are therefore separated by exactly one idle 0 bit. Throughput is one word per L+1 cycles.
- **Reset during a frame:** the frame is aborted immediately. The line drops to 0 with no STOP symbol, and no `done` is issued.
- **`rst_n` deasserted with `valid_in` already high:** accept happens on the first rising edge after deassertion.

## Structure
- Package `pair_pkg`:
  - State enum (IDLE/PRE/DATA/STOP).
  - 2-bit symbol constants SYM_PRE = 2'b01, SYM_ONE = 2'b11, SYM_ZERO = 2'b10, SYM_STOP = 2'b00.
  - An encode function: bit → symbol.
- The pair detector and the future `pair_rx` decoder share this package.
- Single module; no sub-module needed. The shift register stays inline.

## Test plan
- **Reset values:** assert `rst_n` = 0 mid-cycle → `outp` = 0, `ready_out` = 1, `busy` = 0 and `done` = 0 immediately, without waiting for a clock edge.
- **Single frame at defaults:** `data_in` = 8'hA5 with one-cycle `valid_in` → `outp` carries 01 01 11 10 11 10 10 11 10 11 00 (22 bits). `done` is high on cycle 22. `ready_out` is high on cycle 23.
- **Back-to-back:** `valid_in` held high with 8'hFF then 8'h00 → the second frame starts after exactly one idle 0. Its data field is eight 10 symbols.
- **Busy ignore:** pulse `valid_in` with 8'h3C at cycle 5 of a frame carrying 8'h01 → only the 8'h01 frame is sent. `ready_out` stays 0 until after `done`.
- **Reset mid-frame:** `rst_n` low at cycle 10 of the frame → `outp` = 0 at once and `done` never pulses. After release, a new 8'h5A frame is sent correctly.
- **Parameters:** `DATA_W` = 4, `PRE_PAIRS` = 1, data 4'b0110 → line carries 01 10 11 11 10 00. `done` is high on cycle 12.
